// File: rtl/tensor_core_tile_sequencer.sv
// tensor_core_tile_sequencer: steps the 4x4 GEMM over a K-loop of tiles,
// holding the carry-save accumulator between steps and returning the final planes.
module tensor_core_tile_sequencer #(
    parameter int NUM      = 4,
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = 92,
    parameter int KW       = 8,
    parameter int GEMM_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [KW-1:0]                k_steps,
    input  logic                         acc_init,
    input  logic [NUM*NUM*AWIDTH-1:0]    C_init_sum,
    input  logic [NUM*NUM*AWIDTH-1:0]    C_init_carry,
    input  logic                         abort,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [NUM*NUM*DWIDTH-1:0]    A_in,
    input  logic [NUM*NUM*DWIDTH-1:0]    B_in,
    output logic [NUM*NUM*DWIDTH-1:0]    gemm_A,
    output logic [NUM*NUM*DWIDTH-1:0]    gemm_B,
    output logic [NUM*NUM*AWIDTH-1:0]    gemm_C_sum,
    output logic [NUM*NUM*AWIDTH-1:0]    gemm_C_carry,
    output logic                         gemm_C_valid,
    input  logic [NUM*NUM*AWIDTH-1:0]    gemm_sum_res,
    input  logic [NUM*NUM*AWIDTH-1:0]    gemm_carry_res,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [NUM*NUM*AWIDTH-1:0]    res_sum,
    output logic [NUM*NUM*AWIDTH-1:0]    res_carry,
    output logic                         busy,
    output logic [KW-1:0]                step_cnt
);
    localparam int P  = NUM*NUM*AWIDTH;
    localparam int WW = GEMM_LAT > 1 ? $clog2(GEMM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t        state, next;
    logic [KW-1:0] k_reg;
    logic          init_flag;
    logic [WW-1:0] wait_cnt;
    logic [P-1:0]  acc_sum, acc_carry;
    logic          start_acc, op_fire, cap;

    assign start_acc    = state == IDLE && start && !abort;
    assign op_fire      = op_valid && op_ready;
    assign cap          = state == CALC && !abort && wait_cnt == '0;
    assign gemm_C_sum   = acc_sum;
    assign gemm_C_carry = acc_carry;
    assign res_sum      = acc_sum;
    assign res_carry    = acc_carry;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: next = start_acc ? (k_steps == '0 ? DONE : LOAD) : IDLE;
            LOAD: next = op_fire ? CALC : LOAD;
            CALC: next = cap ? (step_cnt + 1'b1 == k_reg ? DONE : LOAD) : CALC;
            DONE: next = res_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
        if (abort)
            next = IDLE;
    end

    always_comb begin
        op_ready     = state == LOAD && !abort;
        res_valid    = state == DONE && !abort;
        busy         = state != IDLE;
        gemm_C_valid = state == CALC && (step_cnt != '0 || init_flag);
    end

    // The accumulator doubles as the result register, so DONE needs no extra copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_reg     <= '0;
            init_flag <= 1'b0;
            wait_cnt  <= '0;
            step_cnt  <= '0;
            acc_sum   <= '0;
            acc_carry <= '0;
            gemm_A    <= '0;
            gemm_B    <= '0;
        end else begin
            if (start_acc) begin
                k_reg     <= k_steps;
                init_flag <= acc_init;
                step_cnt  <= '0;
                acc_sum   <= acc_init ? C_init_sum : '0;
                acc_carry <= acc_init ? C_init_carry : '0;
            end
            if (op_fire) begin
                gemm_A   <= A_in;
                gemm_B   <= B_in;
                wait_cnt <= WW'(GEMM_LAT - 1);
            end
            if (state == CALC && !abort && wait_cnt != '0)
                wait_cnt <= wait_cnt - 1'b1;
            if (cap) begin
                acc_sum   <= gemm_sum_res;
                acc_carry <= gemm_carry_res;
                step_cnt  <= step_cnt + 1'b1;
            end
            if (abort && state != IDLE)
                step_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_tensor_core_tile_sequencer.sv
// tb_tensor_core_tile_sequencer: vector table of whole jobs plus directed
// sequences for DONE hold, abort and mid-job reset, against a stand-in GEMM.
module tb_tensor_core_tile_sequencer;
    localparam int N = 4, DW = 16, AW = 92, KW = 8;
    localparam int P = N*N*AW, Q = N*N*DW;

    logic          clk = 0, rst_n = 0, start = 0, acc_init = 0, abort = 0;
    logic          op_valid = 0, res_ready = 0;
    logic [KW-1:0] k_steps = '0;
    logic [P-1:0]  C_init_sum = '0, C_init_carry = '0;
    logic [Q-1:0]  A_in = '0, B_in = '0;
    logic          op_ready, gemm_C_valid, res_valid, busy;
    logic [Q-1:0]  gemm_A, gemm_B;
    logic [P-1:0]  gemm_C_sum, gemm_C_carry, gemm_sum_res, gemm_carry_res, res_sum, res_carry;
    logic [KW-1:0] step_cnt;
    logic [Q-1:0]  ident;

    int checks = 0, failures = 0;

    tensor_core_tile_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_steps(k_steps), .acc_init(acc_init),
        .C_init_sum(C_init_sum), .C_init_carry(C_init_carry), .abort(abort),
        .op_valid(op_valid), .op_ready(op_ready), .A_in(A_in), .B_in(B_in),
        .gemm_A(gemm_A), .gemm_B(gemm_B), .gemm_C_sum(gemm_C_sum), .gemm_C_carry(gemm_C_carry),
        .gemm_C_valid(gemm_C_valid), .gemm_sum_res(gemm_sum_res), .gemm_carry_res(gemm_carry_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_carry(res_carry),
        .busy(busy), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in GEMM: sum = C + A + B elementwise, carry = C + 1; C counts only when valid.
    always_comb begin
        gemm_sum_res   = '0;
        gemm_carry_res = '0;
        for (int e = 0; e < N*N; e++) begin
            gemm_sum_res[e*AW +: AW]   = (gemm_C_valid ? gemm_C_sum[e*AW +: AW] : AW'(0))
                                         + AW'(gemm_A[e*DW +: DW]) + AW'(gemm_B[e*DW +: DW]);
            gemm_carry_res[e*AW +: AW] = (gemm_C_valid ? gemm_C_carry[e*AW +: AW] : AW'(0)) + AW'(1);
        end
    end

    function automatic logic [P-1:0] plane(input logic [AW-1:0] d, input logic [AW-1:0] o);
        logic [P-1:0] r;
        for (int e = 0; e < N*N; e++)
            r[e*AW +: AW] = (e / N == e % N) ? d : o;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [P-1:0] act, input logic [P-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (low 64 bits)", nm, act[63:0], exp[63:0]);
        end
    endtask

    task automatic run_job(input logic [KW-1:0] k, input logic init,
                           input logic [AW-1:0] sd, input logic [AW-1:0] so, input logic [AW-1:0] sc,
                           output int cyc, output int hs, output int bad);
        k_steps = k; acc_init = init;
        C_init_sum = plane(sd, so); C_init_carry = plane(sc, sc);
        A_in = ident; B_in = ident;
        start = 1;
        tick();
        start = 0;
        op_valid = 1;
        cyc = 0; hs = 0; bad = 0;
        while (!res_valid && cyc < 200) begin
            if (op_ready) hs++;
            if (busy && !op_ready) begin
                if (gemm_C_valid !== (hs > 1 || init)) bad++;
                if (gemm_A !== ident || gemm_B !== ident) bad++;
            end
            tick();
            cyc++;
        end
        op_valid = 0;
    endtask

    typedef struct {
        logic [KW-1:0] k;
        logic          init;
        logic [AW-1:0] sd, so, sc, ed, eo, ec;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc, hs, bad;
        logic [P-1:0] hold_s, hold_c;
        for (int e = 0; e < N*N; e++)
            ident[e*DW +: DW] = (e / N == e % N) ? 16'h3C00 : 16'h0000;

        vecs[0] = '{k: 8'd1, init: 1'b0, sd: 92'h5,     so: 92'h7,   sc: 92'h3,  ed: 92'h7800,  eo: 92'h0,   ec: 92'h1};
        vecs[1] = '{k: 8'd4, init: 1'b1, sd: 92'h4000,  so: 92'h11,  sc: 92'h2,  ed: 92'h22000, eo: 92'h11,  ec: 92'h6};
        vecs[2] = '{k: 8'd0, init: 1'b1, sd: 92'hABC,   so: 92'h123, sc: 92'h55, ed: 92'hABC,   eo: 92'h123, ec: 92'h55};
        vecs[3] = '{k: 8'd0, init: 1'b0, sd: 92'h9,     so: 92'h9,   sc: 92'h9,  ed: 92'h0,     eo: 92'h0,   ec: 92'h0};
        vecs[4] = '{k: 8'd3, init: 1'b0, sd: 92'h1,     so: 92'h2,   sc: 92'h3,  ed: 92'h16800, eo: 92'h0,   ec: 92'h3};

        tick(); tick();
        chk("rst_busy", P'(busy), P'(0));
        chk("rst_op_ready", P'(op_ready), P'(0));
        chk("rst_res_valid", P'(res_valid), P'(0));
        chk("rst_step_cnt", P'(step_cnt), P'(0));
        chk("rst_cvalid", P'(gemm_C_valid), P'(0));
        chk("rst_res_sum", res_sum, P'(0));
        rst_n = 1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i].k, vecs[i].init, vecs[i].sd, vecs[i].so, vecs[i].sc, cyc, hs, bad);
            chk($sformatf("v%0d_latency", i), P'(cyc), P'(2 * vecs[i].k));
            chk($sformatf("v%0d_tiles", i), P'(hs), P'(vecs[i].k));
            chk($sformatf("v%0d_calc", i), P'(bad), P'(0));
            chk($sformatf("v%0d_sum", i), res_sum, plane(vecs[i].ed, vecs[i].eo));
            chk($sformatf("v%0d_carry", i), res_carry, plane(vecs[i].ec, vecs[i].ec));
            chk($sformatf("v%0d_step_cnt", i), P'(step_cnt), P'(vecs[i].k));
            res_ready = 1;
            tick();
            res_ready = 0;
            chk($sformatf("v%0d_idle", i), P'({busy, res_valid}), P'(0));
        end

        // DONE held with res_ready low while start is pulsed
        run_job(8'd1, 1'b1, 92'h9, 92'h8, 92'h1, cyc, hs, bad);
        hold_s = plane(92'h7809, 92'h8);
        hold_c = plane(92'h2, 92'h2);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            start = (c == 3); k_steps = 8'd5;
            if (!res_valid || !busy || step_cnt != 8'd1 || res_sum !== hold_s || res_carry !== hold_c) bad++;
            tick();
        end
        start = 0;
        chk("hold_stable", P'(bad), P'(0));
        res_ready = 1; start = 1; k_steps = 8'd0; acc_init = 0;
        tick();
        chk("hold_handshake_idle", P'(busy), P'(0));
        res_ready = 0;
        tick();
        start = 0;
        chk("restart_done", P'({res_valid, busy}), P'(3));
        chk("restart_zero", res_sum, P'(0));
        res_ready = 1;
        tick();
        res_ready = 0;

        // abort in CALC of step 2 of 4 with op_valid high
        k_steps = 8'd4; acc_init = 0; A_in = ident; B_in = ident;
        start = 1;
        tick();
        start = 0; op_valid = 1;
        tick(); tick(); tick();
        chk("abort_pre_calc", P'({busy, op_ready, step_cnt}), P'({1'b1, 1'b0, 8'd1}));
        abort = 1;
        tick();
        abort = 0; op_valid = 0;
        chk("abort_idle", P'({busy, res_valid, step_cnt}), P'(0));
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (res_valid || busy) bad++;
            tick();
        end
        chk("abort_quiet", P'(bad), P'(0));
        run_job(8'd2, 1'b0, 92'h7, 92'h7, 92'h7, cyc, hs, bad);
        chk("post_abort_sum", res_sum, plane(92'hF000, 92'h0));
        chk("post_abort_carry", res_carry, plane(92'h2, 92'h2));
        chk("post_abort_steps", P'({hs[7:0], step_cnt}), P'({8'd2, 8'd2}));

        // abort blocks a result handshake in DONE
        abort = 1; res_ready = 1;
        #1;
        chk("abort_masks_res_valid", P'(res_valid), P'(0));
        tick();
        abort = 0; res_ready = 0;
        chk("abort_done_idle", P'(busy), P'(0));

        // abort blocks a tile offered in LOAD
        k_steps = 8'd2; start = 1;
        tick();
        start = 0; op_valid = 1; abort = 1;
        #1;
        chk("abort_masks_op_ready", P'(op_ready), P'(0));
        tick();
        abort = 0; op_valid = 0;
        chk("abort_load_idle", P'(busy), P'(0));

        // reset mid-LOAD after one completed step with a tile pending
        k_steps = 8'd2; acc_init = 1; C_init_sum = plane(92'h33, 92'h44); C_init_carry = plane(92'h5, 92'h5);
        start = 1;
        tick();
        start = 0; op_valid = 1;
        tick(); tick();
        chk("pre_reset_load", P'({op_ready, step_cnt}), P'({1'b1, 8'd1}));
        rst_n = 0;
        tick();
        chk("reset_ctrl", P'({op_ready, busy, res_valid, gemm_C_valid, step_cnt}), P'(0));
        chk("reset_gemm_A", P'(gemm_A), P'(0));
        chk("reset_acc", res_sum | res_carry, P'(0));
        rst_n = 1; op_valid = 1;
        tick();
        op_valid = 0;
        chk("reset_no_consume", P'({busy, step_cnt}), P'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
